// File: rtl/impulse_loader_if.sv
// impulse_loader_if: sample stream in, memory write port and status out.
interface impulse_loader_if #(
    parameter int LANES        = 64,
    parameter int SAMPLE_WIDTH = 16
);
    logic                          start_in;
    logic [SAMPLE_WIDTH-1:0]       sample_in;
    logic                          sample_valid_in;
    logic                          sample_ready_out;
    logic [15:0]                   write_addr;
    logic [LANES*SAMPLE_WIDTH-1:0] write_data;
    logic                          write_enable;
    logic                          busy_out;
    logic                          done_out;
    modport master (
        output start_in, sample_in, sample_valid_in,
        input  sample_ready_out, write_addr, write_data, write_enable, busy_out, done_out
    );
    modport slave (
        input  start_in, sample_in, sample_valid_in,
        output sample_ready_out, write_addr, write_data, write_enable, busy_out, done_out
    );
endinterface

// File: rtl/impulse_loader.sv
// impulse_loader: packs LANES samples per tap into one word and writes taps 0..IMPULSE_LENGTH-1.
module impulse_loader #(
    parameter int IMPULSE_LENGTH = 48000,
    parameter int LANES          = 64,
    parameter int SAMPLE_WIDTH   = 16
) (
    input logic               audio_clk,
    input logic               rst_in,
    impulse_loader_if.slave   bus
);
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1;
    localparam int WW = LANES * SAMPLE_WIDTH;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES - 1);
    localparam logic [15:0]   LAST_TAP  = 16'(IMPULSE_LENGTH - 1);
    typedef enum logic {IDLE, FILL} state_t;
    state_t          state_q, state_d;
    logic [LW-1:0]   lane_q, lane_d;
    logic [15:0]     tap_q, tap_d;
    logic [WW-1:0]   pack_q, pack_d;
    logic [15:0]     addr_q, addr_d;
    logic [WW-1:0]   data_q, data_d;
    logic            we_q, we_d;
    logic            done_q, done_d;
    logic            accept;
    assign accept               = (state_q == FILL) && bus.sample_valid_in;
    assign bus.sample_ready_out = (state_q == FILL);
    assign bus.busy_out         = (state_q == FILL);
    assign bus.write_addr       = addr_q;
    assign bus.write_data       = data_q;
    assign bus.write_enable     = we_q;
    assign bus.done_out         = done_q;
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        tap_d   = tap_q;
        pack_d  = pack_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        done_d  = 1'b0;
        if (state_q == IDLE && bus.start_in) begin
            state_d = FILL;
            lane_d  = '0;
            tap_d   = '0;
        end
        if (accept) begin
            for (int k = 0; k < LANES; k++)
                if (lane_q == LW'(k)) pack_d[k*SAMPLE_WIDTH +: SAMPLE_WIDTH] = bus.sample_in;
            lane_d = (lane_q == LAST_LANE) ? '0 : lane_q + 1'b1;
            // The completed word moves to the output register, freeing pack for the next tap at once.
            if (lane_q == LAST_LANE) begin
                we_d   = 1'b1;
                addr_d = tap_q;
                data_d = pack_d;
                tap_d  = tap_q + 16'd1;
                if (tap_q == LAST_TAP) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
        end
    end
    always_ff @(posedge audio_clk) begin
        if (rst_in) begin
            state_q <= IDLE;
            lane_q  <= '0;
            tap_q   <= '0;
            pack_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            tap_q   <= tap_d;
            pack_q  <= pack_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            done_q  <= done_d;
        end
    end
endmodule
